// File: rtl/foc_clk_pkg.sv
// Shared constants for the FOC clock-enable scheduler: default field width,
// channel indices and the per-channel state encoding.
package foc_clk_pkg;

    localparam int unsigned DIV_W_DEF = 16;

    localparam int unsigned CH_PWM  = 0;
    localparam int unsigned CH_ADC  = 1;
    localparam int unsigned CH_LOOP = 2;

    localparam logic [1:0] ST_OFF      = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_RUN_PEND = 2'd2;
    localparam logic [1:0] ST_OFF_PEND = 2'd3;

endpackage

// File: rtl/foc_tick_chan.sv
// One tick channel: period counter, shadow/active config, state machine and
// registered tick / square-wave outputs.
module foc_tick_chan
    import foc_clk_pkg::*;
#(
    parameter int unsigned DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_we,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [DIV_W-1:0] cfg_phase,
    output logic             pend_o,
    output logic             tick_o,
    output logic             sq_o
);

    logic [1:0]       st_q, st_d;
    logic [DIV_W-1:0] act_div_q, act_div_d;
    logic [DIV_W-1:0] act_ph_q, act_ph_d;
    logic [DIV_W-1:0] sh_div_q, sh_div_d;
    logic [DIV_W-1:0] sh_ph_q, sh_ph_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;

    logic [DIV_W-1:0] div_m1;
    logic [DIV_W-1:0] half;
    logic             run;
    logic             wrap;
    logic             apply;

    always_comb begin
        div_m1 = act_div_q - DIV_W'(1);
        half   = (act_div_q >> 1) + {{(DIV_W-1){1'b0}}, act_div_q[0]};
        run    = en && (st_q == ST_RUN || st_q == ST_RUN_PEND);
        wrap   = run && (cnt_q == div_m1);

        st_d      = st_q;
        act_div_d = act_div_q;
        act_ph_d  = act_ph_q;
        sh_div_d  = sh_div_q;
        sh_ph_d   = sh_ph_q;
        apply     = 1'b0;

        tick_d = run && (cnt_q == act_ph_q);
        sq_d   = run && (cnt_q < half);
        cnt_d  = (run && !wrap) ? cnt_q + DIV_W'(1) : '0;

        unique case (st_q)
            ST_OFF:      if (cfg_we) st_d = ST_OFF_PEND;
            ST_RUN:      if (cfg_we) st_d = ST_RUN_PEND;
            // A stopped channel has no period to protect, so apply at once.
            ST_RUN_PEND: apply = !en || wrap;
            ST_OFF_PEND: apply = 1'b1;
            default:     st_d = ST_OFF;
        endcase

        if (apply) begin
            act_div_d = sh_div_q;
            act_ph_d  = sh_ph_q;
            cnt_d     = '0;
            st_d      = (sh_div_q != '0) ? ST_RUN : ST_OFF;
        end

        if (cfg_we) begin
            sh_div_d = cfg_div;
            sh_ph_d  = cfg_phase;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q      <= ST_OFF;
            act_div_q <= '0;
            act_ph_q  <= '0;
            sh_div_q  <= '0;
            sh_ph_q   <= '0;
            cnt_q     <= '0;
            tick_q    <= 1'b0;
            sq_q      <= 1'b0;
        end else begin
            st_q      <= st_d;
            act_div_q <= act_div_d;
            act_ph_q  <= act_ph_d;
            sh_div_q  <= sh_div_d;
            sh_ph_q   <= sh_ph_d;
            cnt_q     <= cnt_d;
            tick_q    <= tick_d;
            sq_q      <= sq_d;
        end
    end

    assign pend_o = (st_q == ST_RUN_PEND) || (st_q == ST_OFF_PEND);
    assign tick_o = tick_q;
    assign sq_o   = sq_q;

endmodule

// File: rtl/foc_tick_sched.sv
// Programmable clock-enable scheduler: config handshake decode, phase clamp,
// error pulse and NCH tick channels.
module foc_tick_sched
    import foc_clk_pkg::*;
#(
    parameter int unsigned NCH   = 3,
    parameter int unsigned DIV_W = DIV_W_DEF,
    localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [DIV_W-1:0] cfg_phase,
    output logic             cfg_err,
    output logic [NCH-1:0]   tick_o,
    output logic [NCH-1:0]   sq_o,
    output logic [NCH-1:0]   pend_o
);

    logic [NCH-1:0]         pend;
    logic [NCH-1:0]         cfg_we;
    logic [(1<<CH_W)-1:0]   pend_ext;
    logic                   ch_ok;
    logic                   accept;
    logic                   over;
    logic [DIV_W-1:0]       phase_c;
    logic                   cfg_err_q, cfg_err_d;

    // Unused index codes read as "not pending" and are silently dropped.
    always_comb begin
        pend_ext           = '0;
        pend_ext[NCH-1:0]  = pend;
        cfg_ready          = ~pend_ext[cfg_ch];
        ch_ok              = (32'(cfg_ch) < NCH);
        accept             = cfg_valid && cfg_ready && ch_ok;
        over               = (cfg_div != '0) && (cfg_phase >= cfg_div);
        if (cfg_div == '0) begin
            phase_c = '0;
        end else if (over) begin
            phase_c = cfg_div - DIV_W'(1);
        end else begin
            phase_c = cfg_phase;
        end
        cfg_err_d = accept && over;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_err = cfg_err_q;
    assign pend_o  = pend;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        assign cfg_we[i] = accept && (cfg_ch == CH_W'(i));

        foc_tick_chan #(
            .DIV_W (DIV_W)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en),
            .cfg_we    (cfg_we[i]),
            .cfg_div   (cfg_div),
            .cfg_phase (phase_c),
            .pend_o    (pend[i]),
            .tick_o    (tick_o[i]),
            .sq_o      (sq_o[i])
        );
    end

endmodule

// File: tb/tb_foc_tick_sched.sv
// Bench for foc_tick_sched: directed scenarios plus random traffic, checked
// against a model that tracks each channel as a tick train anchored in time.
module tb_foc_tick_sched;
    import foc_clk_pkg::*;

    localparam int NCH   = 3;
    localparam int DIV_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [1:0]       cfg_ch = '0;
    logic [DIV_W-1:0] cfg_div = '0;
    logic [DIV_W-1:0] cfg_phase = '0;
    logic             cfg_err;
    logic [NCH-1:0]   tick_o, sq_o, pend_o;

    foc_tick_sched #(
        .NCH   (NCH),
        .DIV_W (DIV_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_phase (cfg_phase),
        .cfg_err   (cfg_err),
        .tick_o    (tick_o),
        .sq_o      (sq_o),
        .pend_o    (pend_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: a running channel ticks when (cycle - start) mod div == phase.
    int m_div[NCH], m_ph[NCH], m_start[NCH], s_div[NCH], s_ph[NCH];
    bit m_pend[NCH];
    int cyc = 0;
    logic [NCH-1:0] e_tick, e_sq, e_pend;
    logic e_err, e_ready, obs_ready;

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_div[i] = 0; m_ph[i] = 0; m_start[i] = 0;
            s_div[i] = 0; s_ph[i] = 0; m_pend[i] = 0;
        end
        e_tick = '0; e_sq = '0; e_pend = '0; e_err = 1'b0;
    endtask

    task automatic model_clock();
        int  pos;
        bit  on;
        int  ch;
        bit  slot_free;
        ch = int'(cfg_ch);
        slot_free = (ch >= NCH) ? 1'b1 : !m_pend[ch];
        for (int i = 0; i < NCH; i++) begin
            on = en && (m_div[i] != 0);
            pos = on ? (cyc - m_start[i]) % m_div[i] : 0;
            e_tick[i] = on && (pos == m_ph[i]);
            e_sq[i]   = on && (pos < (m_div[i] + 1) / 2);
            if (m_pend[i] && (!en || m_div[i] == 0 || pos == m_div[i] - 1)) begin
                m_div[i] = s_div[i];
                m_ph[i] = s_ph[i];
                m_pend[i] = 0;
                m_start[i] = cyc + 1;
            end else if (!en) begin
                m_start[i] = cyc + 1;
            end
        end
        e_err = 1'b0;
        if (cfg_valid && ch < NCH && slot_free) begin
            s_div[ch] = int'(cfg_div);
            if (cfg_div == 0) s_ph[ch] = 0;
            else if (cfg_phase >= cfg_div) s_ph[ch] = int'(cfg_div) - 1;
            else s_ph[ch] = int'(cfg_phase);
            e_err = (cfg_div != 0) && (cfg_phase >= cfg_div);
            m_pend[ch] = 1;
        end
        for (int i = 0; i < NCH; i++) e_pend[i] = m_pend[i];
        cyc++;
    endtask

    // Drive one cycle of inputs, update the model, sample on the falling edge.
    task automatic step(input logic e, input logic v, input logic [1:0] ch,
                        input int d, input int p);
        en = e; cfg_valid = v; cfg_ch = ch;
        cfg_div = d[DIV_W-1:0]; cfg_phase = p[DIV_W-1:0];
        #1;
        obs_ready = cfg_ready;
        e_ready = (int'(ch) >= NCH) ? 1'b1 : !m_pend[int'(ch)];
        model_clock();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int pos_now(input int i);
        return (m_div[i] == 0) ? -1 : (cyc - m_start[i]) % m_div[i];
    endfunction

    task automatic test_reset();
        model_reset();
        rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        checks++;
        if ({tick_o, sq_o, pend_o, cfg_err, cfg_ready} !== {10'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_vals got tick=%b sq=%b pend=%b err=%b rdy=%b want zeros rdy=1",
                     tick_o, sq_o, pend_o, cfg_err, cfg_ready);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 100; k++) begin
            step(1'b1, 1'b0, 2'd0, 0, 0);
            checks++;
            if ({tick_o, sq_o, obs_ready} !== {6'b0, 1'b1}) begin
                errors++;
                $display("FAIL reset_idle k=%0d got tick=%b sq=%b rdy=%b want 0 0 1",
                         k, tick_o, sq_o, obs_ready);
            end
        end
    endtask

    task automatic test_div3();
        int pend_cnt;
        pend_cnt = 0;
        step(1'b1, 1'b1, 2'(CH_PWM), 3, 0);
        if (pend_o[0]) pend_cnt++;
        for (int k = 0; k < 12; k++) begin
            step(1'b1, 1'b0, 2'd0, 0, 0);
            if (pend_o[0]) pend_cnt++;
            checks++;
            if ({tick_o, sq_o, pend_o, cfg_err, obs_ready} !== {e_tick, e_sq, e_pend, e_err, e_ready}) begin
                errors++;
                $display("FAIL div3_model k=%0d got %b/%b/%b/%b/%b want %b/%b/%b/%b/%b", k,
                         tick_o, sq_o, pend_o, cfg_err, obs_ready, e_tick, e_sq, e_pend, e_err, e_ready);
            end
            if (k >= 1) begin
                checks++;
                if ({tick_o[0], sq_o[0]} !== {((k - 1) % 3 == 0), ((k - 1) % 3 < 2)}) begin
                    errors++;
                    $display("FAIL div3_pattern k=%0d got tick=%b sq=%b", k, tick_o[0], sq_o[0]);
                end
            end
        end
        checks++;
        if (pend_cnt !== 1) begin
            errors++;
            $display("FAIL div3_pend_len got %0d want 1", pend_cnt);
        end
    endtask

    task automatic test_reconfig();
        int last_tick, new_tick;
        bit found;
        last_tick = -1; new_tick = -1; found = 0;
        step(1'b1, 1'b1, 2'(CH_PWM), 4, 1);
        for (int k = 0; k < 40 && !found; k++) begin
            if (m_div[0] == 4 && !m_pend[0] && pos_now(0) == 2) begin
                found = 1;
            end else begin
                step(1'b1, 1'b0, 2'd0, 0, 0);
                if (tick_o[0]) last_tick = cyc - 1;
                checks++;
                if ({tick_o, sq_o, pend_o, cfg_err} !== {e_tick, e_sq, e_pend, e_err}) begin
                    errors++;
                    $display("FAIL reconf_model got %b/%b/%b/%b want %b/%b/%b/%b",
                             tick_o, sq_o, pend_o, cfg_err, e_tick, e_sq, e_pend, e_err);
                end
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reconf_wait got no cnt=2 slot want one within 40 cycles");
        end
        step(1'b1, 1'b1, 2'(CH_PWM), 6, 5);
        checks++;
        if ({pend_o[0], obs_ready} !== 2'b11) begin
            errors++;
            $display("FAIL reconf_accept got pend=%b rdy=%b want 1 1", pend_o[0], obs_ready);
        end
        step(1'b1, 1'b1, 2'(CH_PWM), 2, 0);
        checks++;
        if ({obs_ready, pend_o[0]} !== 2'b00) begin
            errors++;
            $display("FAIL reconf_busy got rdy=%b pend_after_wrap=%b want 0 0", obs_ready, pend_o[0]);
        end
        for (int k = 0; k < 12; k++) begin
            step(1'b1, 1'b0, 2'd0, 0, 0);
            if (tick_o[0] && new_tick < 0) new_tick = cyc - 1;
            checks++;
            if ({tick_o, sq_o, pend_o, cfg_err} !== {e_tick, e_sq, e_pend, e_err}) begin
                errors++;
                $display("FAIL reconf_model2 got %b/%b/%b/%b want %b/%b/%b/%b",
                         tick_o, sq_o, pend_o, cfg_err, e_tick, e_sq, e_pend, e_err);
            end
        end
        checks++;
        if (new_tick - last_tick !== 8) begin
            errors++;
            $display("FAIL reconf_gap got %0d want 8", new_tick - last_tick);
        end
    endtask

    task automatic test_wrap_accept();
        int pend_cnt, old_ticks;
        bit found;
        pend_cnt = 0; old_ticks = 0; found = 0;
        step(1'b1, 1'b1, 2'(CH_ADC), 5, 2);
        for (int k = 0; k < 20 && !found; k++) begin
            if (m_div[1] == 5 && !m_pend[1] && pos_now(1) == 4) found = 1;
            else step(1'b1, 1'b0, 2'd0, 0, 0);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wrap_wait got no wrap slot want one within 20 cycles");
        end
        step(1'b1, 1'b1, 2'(CH_ADC), 3, 1);
        if (pend_o[1]) pend_cnt++;
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b0, 2'd0, 0, 0);
            if (pend_o[1]) pend_cnt++;
            if (k < 5 && tick_o[1]) old_ticks++;
            checks++;
            if ({tick_o, sq_o, pend_o, cfg_err} !== {e_tick, e_sq, e_pend, e_err}) begin
                errors++;
                $display("FAIL wrap_model k=%0d got %b/%b/%b/%b want %b/%b/%b/%b", k,
                         tick_o, sq_o, pend_o, cfg_err, e_tick, e_sq, e_pend, e_err);
            end
        end
        checks++;
        if ({pend_cnt, old_ticks} !== {32'd5, 32'd1}) begin
            errors++;
            $display("FAIL wrap_repeat got pend_len=%0d old_ticks=%0d want 5 1", pend_cnt, old_ticks);
        end
    endtask

    task automatic test_clamp();
        int ticks;
        ticks = 0;
        step(1'b1, 1'b1, 2'(CH_LOOP), 5, 7);
        checks++;
        if (cfg_err !== 1'b1) begin
            errors++;
            $display("FAIL clamp_err got %b want 1", cfg_err);
        end
        for (int k = 0; k < 16; k++) begin
            step(1'b1, 1'b0, 2'd0, 0, 0);
            if (tick_o[2]) ticks++;
            if (k == 0) begin
                checks++;
                if (cfg_err !== 1'b0) begin
                    errors++;
                    $display("FAIL clamp_err_len got %b want 0", cfg_err);
                end
            end
            checks++;
            if ({tick_o, sq_o, pend_o, cfg_err} !== {e_tick, e_sq, e_pend, e_err}) begin
                errors++;
                $display("FAIL clamp_model k=%0d got %b/%b/%b/%b want %b/%b/%b/%b", k,
                         tick_o, sq_o, pend_o, cfg_err, e_tick, e_sq, e_pend, e_err);
            end
        end
        checks++;
        if (ticks !== 3) begin
            errors++;
            $display("FAIL clamp_ticks got %0d want 3", ticks);
        end
        step(1'b1, 1'b1, 2'(CH_LOOP), 0, 3);
        checks++;
        if (cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL off_err got %b want 0", cfg_err);
        end
        for (int k = 0; k < 12; k++) begin
            step(1'b1, 1'b0, 2'd0, 0, 0);
            if (k >= 6) begin
                checks++;
                if ({tick_o[2], sq_o[2], pend_o[2]} !== 3'b000) begin
                    errors++;
                    $display("FAIL off_silent k=%0d got tick=%b sq=%b pend=%b want 0 0 0",
                             k, tick_o[2], sq_o[2], pend_o[2]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int pass = 0; pass < 2; pass++) begin
            step(1'b1, 1'b1, 2'd0, 2, 1);
            step(1'b1, 1'b1, 2'd1, 3, 2);
            step(1'b1, 1'b1, 2'd2, 4, 3);
            for (int k = 0; k < 13; k++) begin
                step(1'b1, 1'b0, 2'd0, 0, 0);
                checks++;
                if ({tick_o, sq_o, pend_o, cfg_err} !== {e_tick, e_sq, e_pend, e_err}) begin
                    errors++;
                    $display("FAIL rstmid_model pass=%0d k=%0d got %b/%b/%b/%b want %b/%b/%b/%b",
                             pass, k, tick_o, sq_o, pend_o, cfg_err, e_tick, e_sq, e_pend, e_err);
                end
            end
            if (pass == 0) begin
                // Leave a config pending on ch0 so the reset must also drop it.
                step(1'b1, 1'b1, 2'd0, 7, 0);
                #2 rst_n = 1'b0;
                #1;
                checks++;
                if ({tick_o, sq_o, pend_o, cfg_err, cfg_ready} !== {10'b0, 1'b1}) begin
                    errors++;
                    $display("FAIL rstmid_clear got tick=%b sq=%b pend=%b err=%b rdy=%b want zeros rdy=1",
                             tick_o, sq_o, pend_o, cfg_err, cfg_ready);
                end
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
    endtask

    task automatic test_random();
        logic e, v;
        for (int k = 0; k < 400; k++) begin
            e = ($urandom_range(0, 15) != 0);
            v = ($urandom_range(0, 2) == 0);
            step(e, v, 2'($urandom_range(0, 2)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 9)));
            checks++;
            if ({tick_o, sq_o, pend_o, cfg_err, obs_ready} !== {e_tick, e_sq, e_pend, e_err, e_ready}) begin
                errors++;
                $display("FAIL random k=%0d got %b/%b/%b/%b/%b want %b/%b/%b/%b/%b", k,
                         tick_o, sq_o, pend_o, cfg_err, obs_ready, e_tick, e_sq, e_pend, e_err, e_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_div3();
        test_reconfig();
        test_wrap_accept();
        test_clamp();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
